// File: rtl/ifetch_queue_pkg.sv
// Shared defaults for the instruction-fetch front-end. The widths here must track
// the instruction word encoding used by the core.
package ifetch_queue_pkg;

  localparam int IFQ_INSTR_W  = 16;
  localparam int IFQ_ADDR_W   = 8;
  localparam int IFQ_RESET_PC = 0;
  localparam int IFQ_DEPTH    = 4;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Single-clock FIFO with push/pop/flush. DEPTH must be a power of two so the
// pointers wrap naturally. Head data is read combinationally from registered storage.
module sync_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [WIDTH-1:0]          head_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; count/pointers define what
  // is valid, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues credit-limited sequential
// requests, buffers in-order responses and drops stale ones after a redirect.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int ADDR_W   = IFQ_ADDR_W,
  parameter int INSTR_W  = IFQ_INSTR_W,
  parameter int DEPTH    = IFQ_DEPTH,
  parameter int RESET_PC = IFQ_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int CW = cnt_w(DEPTH);
  localparam int EW = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic              active;

  logic              credit_ok;
  logic              req_fire;
  logic              rsp_keep;
  logic              instr_pop;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [ADDR_W-1:0] pcq_head;

  logic              unused_fifo_full;
  logic              unused_pcq_full;
  logic              unused_pcq_empty;
  logic [CW-1:0]     unused_pcq_count;

  // Every request in flight already owns a FIFO slot, so responses need no ready.
  assign credit_ok      = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
  assign imem_req_valid = reset && active && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0);

  assign instr_valid = !fifo_empty;
  assign instr_pop   = instr_valid && instr_ready && !redirect_valid;
  assign instr_data  = instr_valid ? fifo_head[EW-1 -: INSTR_W] : '0;
  assign instr_pc    = instr_valid ? fifo_head[ADDR_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= ADDR_W'(RESET_PC);
      outstanding <= '0;
      drop_cnt    <= '0;
      active      <= 1'b0;
    end else begin
      active      <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        // Everything still in flight after this cycle predates the redirect.
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(1);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data ({imem_rsp_data, pcq_head}),
    .pop       (instr_pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Request PCs are never flushed: entries track outstanding, stale or not.
  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .head_data (pcq_head),
    .full      (unused_pcq_full),
    .empty     (unused_pcq_empty),
    .count     (unused_pcq_count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [7:0]  imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [7:0]  instr_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct { logic [7:0] addr; bit stale; } infl_t;
  typedef struct { logic [7:0] pc; logic [15:0] data; } ent_t;
  typedef struct { int due; logic [7:0] addr; } mreq_t;

  infl_t      m_infl[$];
  ent_t       m_fifo[$];
  mreq_t      mq[$];
  ent_t       del[$];
  logic [7:0] fires[$];
  logic [7:0] m_pc;
  bit         m_started, m_known;
  int         cyc, lat, checks, failures, first_fire, first_valid, n, pre;
  bit         last_rsp, last_ivalid;

  function automatic logic [15:0] imem_fn(input logic [7:0] a);
    return 16'h1001 + {8'h00, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_rec();
    del.delete();
    fires.delete();
    first_fire  = -1;
    first_valid = -1;
  endtask

  task automatic model_update(input bit exp_req);
    bit         keep;
    logic [7:0] raddr;
    if (!reset) begin
      m_fifo.delete();
      m_infl.delete();
      m_pc      = 8'h00;
      m_started = 0;
      m_known   = 1;
      return;
    end
    keep  = 0;
    raddr = '0;
    if (imem_rsp_valid) begin
      check("rsp_has_req", m_infl.size() > 0, 1);
      if (m_infl.size() > 0) begin
        keep  = !m_infl[0].stale;
        raddr = m_infl[0].addr;
        void'(m_infl.pop_front());
      end
    end
    if (redirect_valid) begin
      m_fifo.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1;
      m_pc = redirect_pc;
    end else begin
      if (m_fifo.size() > 0 && instr_ready) void'(m_fifo.pop_front());
      if (keep) m_fifo.push_back('{pc: raddr, data: imem_fn(raddr)});
      if (exp_req && imem_req_ready) begin
        m_infl.push_back('{addr: m_pc, stale: 0});
        m_pc = m_pc + 8'h01;
      end
    end
    m_started = 1;
  endtask

  // One clock cycle: drive memory, compare at negedge, advance model, resume after posedge.
  task automatic step();
    bit   exp_req;
    ent_t head;
    if (!reset) begin
      mq.delete();
      imem_rsp_valid = 0;
      imem_rsp_data  = '0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = imem_fn(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data  = 16'($urandom);
    end
    @(negedge clk);
    exp_req = reset && m_started && !redirect_valid && (m_fifo.size() + m_infl.size() < DEPTH);
    if (m_known) begin
      if (m_fifo.size() > 0) head = m_fifo[0];
      else begin
        head.pc   = '0;
        head.data = '0;
      end
      check("req_valid",   imem_req_valid, exp_req);
      check("req_addr",    imem_req_addr,  m_pc);
      check("instr_valid", instr_valid,    m_fifo.size() > 0);
      check("instr_data",  instr_data,     head.data);
      check("instr_pc",    instr_pc,       head.pc);
    end
    last_rsp    = imem_rsp_valid;
    last_ivalid = instr_valid;
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (reset && !redirect_valid && instr_valid && instr_ready)
      del.push_back('{pc: instr_pc, data: instr_data});
    if (imem_req_valid && imem_req_ready) begin
      fires.push_back(imem_req_addr);
      mq.push_back('{due: cyc + lat, addr: imem_req_addr});
      if (first_fire < 0) first_fire = cyc;
    end
    model_update(exp_req);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    step();
    reset = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; lat = 1;
    m_known = 0; m_started = 0; m_pc = '0;
    reset = 0; instr_ready = 1; imem_req_ready = 1;
    redirect_valid = 0; redirect_pc = '0;
    imem_rsp_valid = 0; imem_rsp_data = '0;
    clear_rec();

    // Reset state
    repeat (2) step();
    check("rst_instr_valid", instr_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_data", instr_data, 0);
    check("rst_instr_pc", instr_pc, 0);

    // Streaming, 1-cycle memory
    reset = 1;
    clear_rec();
    repeat (12) step();
    check("stream_latency", first_valid - first_fire, 2);
    check("stream_count_ok", del.size() >= 6, 1);
    for (int i = 0; i < 6 && i < del.size(); i++) begin
      check("stream_pc", del[i].pc, i);
      check("stream_data", del[i].data, 16'h1001 + 16'(i));
    end

    // Backpressure
    do_reset();
    instr_ready = 0;
    clear_rec();
    repeat (10) step();
    check("bp_fires", fires.size(), 4);
    for (int i = 0; i < 4 && i < fires.size(); i++) check("bp_addr", fires[i], i);
    check("bp_req_valid", imem_req_valid, 0);
    check("bp_head_data", instr_data, 16'h1001);
    check("bp_full", dut.u_instr_fifo.full, 1);
    instr_ready = 1;
    repeat (10) step();
    check("bp_drain_ok", (del.size() >= 5) && (fires.size() >= 5), 1);
    for (int i = 0; i < 5 && i < del.size(); i++) check("bp_drain_pc", del[i].pc, i);
    if (fires.size() >= 5) check("bp_resume_addr", fires[4], 8'h04);

    // Redirect with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3;
    n = 0;
    while (m_infl.size() != 2 && n < 20) begin step(); n++; end
    check("rd_setup", m_infl.size(), 2);
    redirect_valid = 1;
    redirect_pc = 8'h40;
    del.delete();
    step();
    redirect_valid = 0;
    check("rd_drop_cnt", dut.drop_cnt, 2);
    check("rd_instr_valid_after", instr_valid, 0);
    repeat (12) step();
    check("rd_count_ok", del.size() >= 2, 1);
    if (del.size() >= 2) begin
      check("rd_first_pc", del[0].pc, 8'h40);
      check("rd_first_data", del[0].data, 16'h1041);
      check("rd_second_pc", del[1].pc, 8'h41);
    end

    // Redirect coinciding with a response and a decode pop
    lat = 2;
    n = 0;
    while (!(m_fifo.size() > 0 && mq.size() > 0 && mq[0].due <= cyc && m_infl.size() >= 2) && n < 30) begin
      step();
      n++;
    end
    pre = m_infl.size();
    redirect_valid = 1;
    redirect_pc = 8'h80;
    del.delete();
    step();
    redirect_valid = 0;
    check("sim_rsp_seen", last_rsp, 1);
    check("sim_pop_seen", last_ivalid, 1);
    check("sim_drop_cnt", dut.drop_cnt, pre - 1);
    check("sim_empty_next", instr_valid, 0);
    repeat (12) step();
    check("sim_count_ok", del.size() >= 3, 1);
    for (int i = 0; i < 3 && i < del.size(); i++) check("sim_pc", del[i].pc, 8'h80 + 8'(i));

    // Address wrap-around
    lat = 1;
    redirect_valid = 1;
    redirect_pc = 8'hFE;
    step();
    redirect_valid = 0;
    del.delete();
    repeat (10) step();
    check("wrap_count_ok", del.size() >= 4, 1);
    if (del.size() >= 4) begin
      check("wrap_pc0", del[0].pc, 8'hFE);
      check("wrap_pc1", del[1].pc, 8'hFF);
      check("wrap_pc2", del[2].pc, 8'h00);
      check("wrap_pc3", del[3].pc, 8'h01);
      check("wrap_data2", del[2].data, 16'h1001);
    end

    // Reset while the FIFO holds three entries
    instr_ready = 0;
    n = 0;
    while (m_fifo.size() != 3 && n < 20) begin step(); n++; end
    check("mrst_setup", m_fifo.size(), 3);
    do_reset();
    #1;
    check("mrst_instr_valid", instr_valid, 0);
    check("mrst_req_valid", imem_req_valid, 0);
    instr_ready = 1;
    clear_rec();
    n = 0;
    while (fires.size() == 0 && n < 10) begin step(); n++; end
    check("mrst_fired", fires.size() > 0, 1);
    if (fires.size() > 0) check("mrst_first_addr", fires[0], 8'h00);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = 8'($urandom);
      lat            = $urandom_range(1, 4);
      reset          = !($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1;
    redirect_valid = 0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
